// File: rtl/bcd_even_pkg.sv
// Shared definition of the F->D->B->9->F code sequence, used by both the
// source counter and the receive-side checker.
package bcd_even_pkg;

   localparam logic [3:0] CODE_F = 4'hF;
   localparam logic [3:0] CODE_D = 4'hD;
   localparam logic [3:0] CODE_B = 4'hB;
   localparam logic [3:0] CODE_9 = 4'h9;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // Illegal codes map to CODE_F so the result is always a legal code.
   function automatic logic [3:0] next_code(input logic [3:0] code);
      logic [3:0] nxt;
      case (code)
         CODE_F:  nxt = CODE_D;
         CODE_D:  nxt = CODE_B;
         CODE_B:  nxt = CODE_9;
         CODE_9:  nxt = CODE_F;
         default: nxt = CODE_F;
      endcase
      return nxt;
   endfunction

   function automatic logic is_legal(input logic [3:0] code);
      logic ok;
      case (code)
         CODE_F, CODE_D, CODE_B, CODE_9: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/bcd_even_next.sv
// Combinational successor/legality lookup for one 4-bit sequence code.
module bcd_even_next
   import bcd_even_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [3:0] next_o,
   output logic       legal_o
);

   assign next_o  = next_code(code_i);
   assign legal_o = is_legal(code_i);

endmodule

// File: rtl/bcd_even_checker.sv
// Receive-side monitor for the F->D->B->9 code stream: acquires lock, flags
// mismatches and keeps saturating cycle/error counters.
module bcd_even_checker
   import bcd_even_pkg::*;
#(
   parameter int LOCK_N = 2,
   parameter int LOSS_N = 2,
   parameter int CNT_W  = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [3:0]       D,
   input  logic             VALID,
   input  logic             CLR,
   output logic             LOCKED,
   output logic             ERR,
   output logic [3:0]       EXP,
   output logic [CNT_W-1:0] CYC_CNT,
   output logic [CNT_W-1:0] ERR_CNT
);

   if (LOCK_N < 1 || LOCK_N > 15) begin : g_bad_lock_n
      $error("bcd_even_checker: LOCK_N must be in 1..15");
   end
   if (LOSS_N < 1 || LOSS_N > 15) begin : g_bad_loss_n
      $error("bcd_even_checker: LOSS_N must be in 1..15");
   end

   localparam logic [3:0]       LOCK_C  = 4'(LOCK_N);
   localparam logic [3:0]       LOSS_C  = 4'(LOSS_N);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [3:0]       exp_q, exp_d;
   logic [3:0]       good_q, good_d;
   logic [3:0]       miss_q, miss_d;
   logic             err_q, err_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] errc_q, errc_d;
   logic             cyc_inc_s, errc_inc_s;

   logic [3:0] d_next_s, exp_next_s, fly_s;
   logic       d_legal_s, exp_legal_s;

   bcd_even_next u_next_d (
      .code_i  (D),
      .next_o  (d_next_s),
      .legal_o (d_legal_s)
   );

   bcd_even_next u_next_exp (
      .code_i  (exp_q),
      .next_o  (exp_next_s),
      .legal_o (exp_legal_s)
   );

   // Flywheel: keep advancing the expectation when the received code is garbage.
   assign fly_s = exp_legal_s ? exp_next_s : CODE_F;

   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      good_d     = good_q;
      miss_d     = miss_q;
      err_d      = 1'b0;
      cyc_inc_s  = 1'b0;
      errc_inc_s = 1'b0;
      if (VALID) begin
         case (state_q)
            ST_HUNT: begin
               if (d_legal_s) begin
                  exp_d   = d_next_s;
                  good_d  = 4'd0;
                  state_d = ST_SYNC;
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_SYNC: begin
               if (!d_legal_s) begin
                  state_d = ST_HUNT;
                  exp_d   = CODE_F;
               end else if (D == exp_q) begin
                  exp_d  = d_next_s;
                  good_d = good_q + 4'd1;
                  if (good_d == LOCK_C) begin
                     state_d = ST_LOCKED;
                     miss_d  = 4'd0;
                  end else begin
                     state_d = ST_SYNC;
                  end
               end else begin
                  exp_d  = d_next_s;
                  good_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (D == exp_q) begin
                  exp_d     = d_next_s;
                  miss_d    = 4'd0;
                  cyc_inc_s = (D == CODE_9);
               end else begin
                  err_d      = 1'b1;
                  errc_inc_s = 1'b1;
                  miss_d     = miss_q + 4'd1;
                  exp_d      = d_legal_s ? d_next_s : fly_s;
                  if (miss_d == LOSS_C) begin
                     state_d = ST_HUNT;
                     exp_d   = CODE_F;
                     good_d  = 4'd0;
                  end else begin
                     state_d = ST_LOCKED;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               exp_d   = CODE_F;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      locked_d = (state_d == ST_LOCKED);

      if (CLR) begin
         cyc_d  = '0;
         errc_d = '0;
      end else begin
         cyc_d  = (cyc_inc_s && cyc_q != CNT_MAX) ? cyc_q + CNT_W'(1) : cyc_q;
         errc_d = (errc_inc_s && errc_q != CNT_MAX) ? errc_q + CNT_W'(1) : errc_q;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_HUNT;
         exp_q    <= CODE_F;
         good_q   <= 4'd0;
         miss_q   <= 4'd0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
         cyc_q    <= '0;
         errc_q   <= '0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         good_q   <= good_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         cyc_q    <= cyc_d;
         errc_q   <= errc_d;
      end
   end

   assign LOCKED  = locked_q;
   assign ERR     = err_q;
   assign EXP     = exp_q;
   assign CYC_CNT = cyc_q;
   assign ERR_CNT = errc_q;

endmodule
